// File: rtl/console_input_conditioner_if.sv
// Signal bundle between the raw console controls and the RIOT/TIA input side.
// The conditioner takes the slave view; whoever drives the raw lines takes master.
interface console_input_conditioner_if;
  logic       CE;
  logic [3:0] joy0;
  logic [3:0] joy1;
  logic       fire0;
  logic       fire1;
  logic       btn_reset;
  logic       btn_select;
  logic       btn_color;
  logic       btn_diff0;
  logic       btn_diff1;
  logic [7:0] PAin;
  logic [7:0] PBin;
  logic       FIRE0_n;
  logic       FIRE1_n;

  modport master (
    output CE, joy0, joy1, fire0, fire1,
    output btn_reset, btn_select,
    output btn_color, btn_diff0, btn_diff1,
    input  PAin, PBin, FIRE0_n, FIRE1_n
  );

  modport slave (
    input  CE, joy0, joy1, fire0, fire1,
    input  btn_reset, btn_select,
    input  btn_color, btn_diff0, btn_diff1,
    output PAin, PBin, FIRE0_n, FIRE1_n
  );
endinterface

// File: rtl/console_input_conditioner.sv
// Synchronises and debounces the 15 raw console lines and packs them
// into the RIOT SWCHA/SWCHB and TIA fire formats.
module console_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1190
) (
  input logic                          CLK,
  input logic                          RES_n,
  console_input_conditioner_if.slave   io
);

  localparam int          N       = 15;
  localparam logic [15:0] LP_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0] w_raw;
  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;
  logic [N-1:0] r_stable;
  logic [2:0]   r_stable_d;
  logic [2:0]   w_rise;
  logic         r_color;
  logic         r_diff0;
  logic         r_diff1;
  logic [3:0]   w_m0;
  logic [3:0]   w_m1;

  // line map: 0-3 joy0, 4-7 joy1, 8/9 fire, 10 reset, 11 select, 12-14 toggles
  assign w_raw = {io.btn_diff1, io.btn_diff0, io.btn_color,
                  io.btn_select, io.btn_reset,
                  io.fire1, io.fire0, io.joy1, io.joy0};

  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_line
    logic [15:0] r_cnt;

    always_ff @(posedge CLK or negedge RES_n) begin
      if (!RES_n) begin
        r_cnt       <= '0;
        r_stable[g] <= 1'b0;
      end else if (io.CE) begin
        if (r_s2[g] == r_stable[g]) begin
          r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
          r_stable[g] <= r_s2[g];
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign w_rise = r_stable[14:12] & ~r_stable_d;

  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n) begin
      r_stable_d <= '0;
      r_color    <= 1'b1;
      r_diff0    <= 1'b0;
      r_diff1    <= 1'b0;
    end else begin
      r_stable_d <= r_stable[14:12];
      if (w_rise[0]) r_color <= ~r_color;
      if (w_rise[1]) r_diff0 <= ~r_diff0;
      if (w_rise[2]) r_diff1 <= ~r_diff1;
    end
  end

  // opposing directions on one axis cancel each other
  function automatic logic [3:0] f_mask(input logic [3:0] d);
    f_mask = {d[3] & ~d[2], d[2] & ~d[3],
              d[1] & ~d[0], d[0] & ~d[1]};
  endfunction

  assign w_m0 = f_mask(r_stable[3:0]);
  assign w_m1 = f_mask(r_stable[7:4]);

  assign io.PAin    = ~{w_m0, w_m1};
  assign io.PBin    = {r_diff1, r_diff0, 2'b00, r_color, 1'b0,
                       ~r_stable[11], ~r_stable[10]};
  assign io.FIRE0_n = ~r_stable[8];
  assign io.FIRE1_n = ~r_stable[9];

endmodule

// File: tb/tb_console_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every cycle,
// a negedge monitor compares; directed scenarios plus random stimulus.
module tb_console_input_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  console_input_conditioner_if bus ();

  console_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK   (clk),
    .RES_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pa;
    logic [7:0] pb;
    logic       f0;
    logic       f1;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a level is accepted once the last D qualified
  // synchronised samples all disagree with the accepted level
  bit [14:0] m_s1, m_s2, m_st;
  bit [2:0]  m_rose;
  bit        m_col = 1'b1;
  bit        m_d0, m_d1;
  bit        win[15][$];

  function automatic bit [14:0] raw_now();
    return {bus.btn_diff1, bus.btn_diff0, bus.btn_color,
            bus.btn_select, bus.btn_reset,
            bus.fire1, bus.fire0, bus.joy1, bus.joy0};
  endfunction

  function automatic void model_edge();
    bit [14:0] raw;
    bit [14:0] nst;
    bit        agree;
    if (rst_n !== 1'b1) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_rose = '0;
      m_col = 1'b1; m_d0 = 1'b0; m_d1 = 1'b0;
      for (int i = 0; i < 15; i++) win[i].delete();
      return;
    end
    raw = raw_now();
    nst = m_st;
    if (bus.CE === 1'b1) begin
      for (int i = 0; i < 15; i++) begin
        win[i].push_back(m_s2[i]);
        if (win[i].size() > D) void'(win[i].pop_front());
        if (win[i].size() == D) begin
          agree = 1'b1;
          for (int k = 0; k < D; k++)
            if (win[i][k] == m_st[i]) agree = 1'b0;
          if (agree) nst[i] = ~m_st[i];
        end
      end
    end
    if (m_rose[0]) m_col = ~m_col;
    if (m_rose[1]) m_d0 = ~m_d0;
    if (m_rose[2]) m_d1 = ~m_d1;
    m_rose = nst[14:12] & ~m_st[14:12];
    m_st = nst;
    m_s2 = m_s1;
    m_s1 = raw;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit [3:0] d;
    bit pressed;
    e.pa = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      d = m_st[p*4 +: 4];
      for (int b = 0; b < 4; b++) begin
        pressed = d[b] && !d[b ^ 1];
        e.pa[(p == 0 ? 4 : 0) + b] = !pressed;
      end
    end
    e.pb = {m_d1, m_d0, 2'b00, m_col, 1'b0, ~m_st[11], ~m_st[10]};
    e.f0 = ~m_st[8];
    e.f1 = ~m_st[9];
    return e;
  endfunction

  always @(posedge clk) begin
    model_edge();
    sb_q.push_back(model_out());
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_PAin", bus.PAin, e.pa);
      check("sb_PBin", bus.PBin, e.pb);
      check("sb_FIRE0_n", bus.FIRE0_n, e.f0);
      check("sb_FIRE1_n", bus.FIRE1_n, e.f1);
    end
  end

  task automatic drive_raw(input bit [14:0] r);
    {bus.btn_diff1, bus.btn_diff0, bus.btn_color,
     bus.btn_select, bus.btn_reset,
     bus.fire1, bus.fire0, bus.joy1, bus.joy0} = r;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit [14:0] r;
    r = '0;
    bus.CE = 1'b1;
    drive_raw('1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_PAin", bus.PAin, 8'hFF);
    check("rst_PBin", bus.PBin, 8'h0B);
    check("rst_FIRE0_n", bus.FIRE0_n, 1'b1);
    check("rst_FIRE1_n", bus.FIRE1_n, 1'b1);

    edges(3);
    drive_raw('0);
    rst_n = 1'b1;
    edges(100);
    check("idle_PAin", bus.PAin, 8'hFF);
    check("idle_PBin", bus.PBin, 8'h0B);

    bus.joy0 = 4'b0001;
    edges(5);
    check("lat_before", bus.PAin, 8'hFF);
    edges(1);
    check("lat_at", bus.PAin, 8'hEF);
    bus.joy0 = 4'b0000;
    edges(5);
    check("rel_before", bus.PAin, 8'hEF);
    edges(1);
    check("rel_at", bus.PAin, 8'hFF);

    bus.fire1 = 1'b1;
    edges(3);
    bus.fire1 = 1'b0;
    edges(10);
    check("glitch3", bus.FIRE1_n, 1'b1);
    bus.fire1 = 1'b1;
    edges(3);
    bus.fire1 = 1'b0;
    edges(1);
    bus.fire1 = 1'b1;
    edges(4);
    bus.fire1 = 1'b0;
    edges(1);
    check("run4_before", bus.FIRE1_n, 1'b1);
    edges(1);
    check("run4_at", bus.FIRE1_n, 1'b0);
    edges(12);

    bus.btn_color = 1'b1;
    edges(8);
    check("color_press", bus.PBin, 8'h03);
    bus.btn_color = 1'b0;
    edges(8);
    check("color_release", bus.PBin, 8'h03);
    bus.btn_color = 1'b1;
    edges(8);
    check("color_press2", bus.PBin, 8'h0B);
    bus.btn_color = 1'b0;
    edges(8);
    bus.btn_diff1 = 1'b1;
    edges(8);
    check("diff1_press", bus.PBin, 8'h8B);
    bus.btn_diff1 = 1'b0;
    edges(8);
    bus.btn_diff1 = 1'b1;
    edges(8);
    bus.btn_diff1 = 1'b0;
    edges(8);
    check("diff1_back", bus.PBin, 8'h0B);

    bus.joy1 = 4'b0011;
    edges(8);
    check("opp_ud", bus.PAin, 8'hFF);
    bus.joy1 = 4'b0111;
    edges(8);
    check("opp_ud_l", bus.PAin, 8'hFB);
    bus.joy1 = 4'b0101;
    edges(8);
    check("opp_u_l", bus.PAin, 8'hFA);
    bus.joy1 = 4'b0000;
    edges(8);

    bus.CE = 1'b0;
    bus.btn_select = 1'b1;
    edges(1000);
    check("ce_hold", bus.PBin, 8'h0B);
    bus.CE = 1'b1;
    edges(D - 1);
    check("ce_before", bus.PBin, 8'h0B);
    edges(1);
    check("ce_at", bus.PBin, 8'h09);
    bus.btn_select = 1'b0;
    edges(8);

    bus.btn_diff0 = 1'b1;
    edges(4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    edges(3);
    check("midrst_PBin", bus.PBin, 8'h0B);
    rst_n = 1'b1;
    edges(2 + D);
    check("midrst_notyet", bus.PBin, 8'h0B);
    edges(1);
    check("midrst_toggle", bus.PBin, 8'h4B);
    edges(20);
    check("midrst_once", bus.PBin, 8'h4B);
    bus.btn_diff0 = 1'b0;
    edges(10);

    r = raw_now();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 15; b++)
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      drive_raw(r);
      bus.CE = ($urandom_range(0, 4) != 0);
      edges(1);
    end

    bus.CE = 1'b1;
    drive_raw('0);
    edges(20);
    check("final_PAin", bus.PAin, 8'hFF);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
